// File: rtl/eth_measurer_multi_coord.sv
// Round-robin ping-pong latency/loss measurer over NUM_CH main/loop interface pairs.
// One sequence is in flight at a time; results are strobed on done with per-channel counters.
module eth_measurer_multi_coord #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 64,
  parameter int LAT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic [15:0]          psize_req,
  input  logic [LAT_W-1:0]     delay_time,
  input  logic [LAT_W-1:0]     timeout,
  output logic [15:0]          psize,
  output logic [63:0]          ping_id,
  output logic [NUM_CH-1:0]    main_tx_trigger,
  output logic [NUM_CH-1:0]    loop_tx_trigger,
  input  logic [NUM_CH-1:0]    main_tx_begin,
  input  logic [NUM_CH-1:0]    loop_tx_begin,
  input  logic [NUM_CH-1:0]    main_rx_valid,
  input  logic [NUM_CH-1:0]    loop_rx_valid,
  input  logic [NUM_CH*64-1:0] main_rx_ping_id,
  input  logic [NUM_CH*64-1:0] loop_rx_ping_id,
  output logic                 done,
  output logic [3:0]           done_ch,
  output logic [1:0]           status,
  output logic [LAT_W-1:0]     ping_time,
  output logic [LAT_W-1:0]     pong_time,
  output logic [CNT_W-1:0]     good_cnt,
  output logic [CNT_W-1:0]     ping_lost_cnt,
  output logic [CNT_W-1:0]     pong_lost_cnt
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_PING_TX, S_PING_WAIT, S_PONG_TX, S_PONG_WAIT
  } state_t;

  state_t            state_r, state_s;
  logic [CH_W-1:0]   cur_ch_r, last_ch_r, sel_ch_s;
  logic              sel_ok_s;
  logic [LAT_W-1:0]  dcnt_r, timer_r, timer_inc_s;
  logic [15:0]       psize_max_s;
  logic [NUM_CH*64-1:0] main_id_sh_s, loop_id_sh_s;
  logic              main_begin_s, loop_begin_s, ping_match_s, pong_match_s;
  logic              delay_hit_s, timed_out_s;
  logic              launch_s, ping_ok_s, ping_lost_s, pong_ok_s, pong_lost_s;
  logic [CNT_W-1:0]  good_arr_r [NUM_CH];
  logic [CNT_W-1:0]  plost_arr_r [NUM_CH];
  logic [CNT_W-1:0]  polost_arr_r [NUM_CH];
  logic [CNT_W-1:0]  good_inc_s, plost_inc_s, polost_inc_s;

  // Next set mask bit strictly after the last served channel, wrapping around.
  function automatic logic [CH_W:0] pick_next(input logic [NUM_CH-1:0] mask,
                                              input logic [CH_W-1:0]   last);
    logic            found;
    logic [CH_W-1:0] ch;
    logic [NUM_CH-1:0] rot;
    found = 1'b0;
    ch    = {CH_W{1'b0}};
    for (int i = 1; i <= NUM_CH; i++) begin
      int idx;
      idx = (int'(last) + i) % NUM_CH;
      rot = mask >> idx;
      if (!found && rot[0]) begin
        found = 1'b1;
        ch    = CH_W'(idx);
      end else begin
        found = found;
      end
    end
    return {found, ch};
  endfunction

  // Per-channel taps, selection and event decode for the channel under test.
  always_comb begin
    {sel_ok_s, sel_ch_s} = pick_next(ch_mask, last_ch_r);
    main_id_sh_s  = main_rx_ping_id >> {cur_ch_r, 6'd0};
    loop_id_sh_s  = loop_rx_ping_id >> {cur_ch_r, 6'd0};
    main_begin_s  = main_tx_begin[cur_ch_r];
    loop_begin_s  = loop_tx_begin[cur_ch_r];
    ping_match_s  = loop_rx_valid[cur_ch_r] && (loop_id_sh_s[63:0] == ping_id);
    pong_match_s  = main_rx_valid[cur_ch_r] && (main_id_sh_s[63:0] == ping_id);
    delay_hit_s   = (dcnt_r == delay_time);
    timed_out_s   = (timer_r == timeout);
    timer_inc_s   = (timer_r == {LAT_W{1'b1}}) ? timer_r : timer_r + {{(LAT_W-1){1'b0}}, 1'b1};
    psize_max_s   = (psize_req < 16'd38) ? 16'd38 : psize_req;
    good_inc_s    = good_arr_r[cur_ch_r]   + {{(CNT_W-1){1'b0}}, 1'b1};
    plost_inc_s   = plost_arr_r[cur_ch_r]  + {{(CNT_W-1){1'b0}}, 1'b1};
    polost_inc_s  = polost_arr_r[cur_ch_r] + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic; dropping enable forces IDLE from anywhere.
  always_comb begin
    state_s = state_r;
    if (!enable) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:      state_s = (ch_mask != {NUM_CH{1'b0}}) ? S_DELAY : S_IDLE;
        S_DELAY:     state_s = !delay_hit_s ? S_DELAY : (sel_ok_s ? S_PING_TX : S_IDLE);
        S_PING_TX:   state_s = main_begin_s ? S_PING_WAIT : S_PING_TX;
        S_PING_WAIT: state_s = ping_match_s ? S_PONG_TX : (timed_out_s ? S_DELAY : S_PING_WAIT);
        S_PONG_TX:   state_s = loop_begin_s ? S_PONG_WAIT : S_PONG_TX;
        S_PONG_WAIT: state_s = (pong_match_s || timed_out_s) ? S_DELAY : S_PONG_WAIT;
        default:     state_s = S_IDLE;
      endcase
    end
  end

  // Output events; a match on the timeout cycle takes priority over loss.
  always_comb begin
    launch_s    = 1'b0;
    ping_ok_s   = 1'b0;
    ping_lost_s = 1'b0;
    pong_ok_s   = 1'b0;
    pong_lost_s = 1'b0;
    if (enable) begin
      case (state_r)
        S_DELAY:     launch_s = delay_hit_s && sel_ok_s;
        S_PING_WAIT: begin
          ping_ok_s   = ping_match_s;
          ping_lost_s = !ping_match_s && timed_out_s;
        end
        S_PONG_WAIT: begin
          pong_ok_s   = pong_match_s;
          pong_lost_s = !pong_match_s && timed_out_s;
        end
        default:     launch_s = 1'b0;
      endcase
    end else begin
      launch_s = 1'b0;
    end
  end

  // Datapath: counters, timers, latched sequence data and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_ch_r        <= {CH_W{1'b0}};
      last_ch_r       <= CH_W'(NUM_CH - 1);
      dcnt_r          <= {LAT_W{1'b0}};
      timer_r         <= {LAT_W{1'b0}};
      psize           <= 16'd0;
      ping_id         <= 64'd0;
      main_tx_trigger <= {NUM_CH{1'b0}};
      loop_tx_trigger <= {NUM_CH{1'b0}};
      done            <= 1'b0;
      done_ch         <= 4'd0;
      status          <= 2'd0;
      ping_time       <= {LAT_W{1'b0}};
      pong_time       <= {LAT_W{1'b0}};
      good_cnt        <= {CNT_W{1'b0}};
      ping_lost_cnt   <= {CNT_W{1'b0}};
      pong_lost_cnt   <= {CNT_W{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        good_arr_r[c]   <= {CNT_W{1'b0}};
        plost_arr_r[c]  <= {CNT_W{1'b0}};
        polost_arr_r[c] <= {CNT_W{1'b0}};
      end
    end else begin
      dcnt_r  <= (state_r == S_DELAY) ? dcnt_r + {{(LAT_W-1){1'b0}}, 1'b1} : {LAT_W{1'b0}};
      timer_r <= (state_r == S_PING_WAIT || state_r == S_PONG_WAIT) ? timer_inc_s : {LAT_W{1'b0}};
      main_tx_trigger <= launch_s  ? (NUM_CH'(1'b1) << sel_ch_s) : {NUM_CH{1'b0}};
      loop_tx_trigger <= ping_ok_s ? (NUM_CH'(1'b1) << cur_ch_r) : {NUM_CH{1'b0}};
      done            <= ping_lost_s | pong_ok_s | pong_lost_s;
      if (launch_s) begin
        cur_ch_r  <= sel_ch_s;
        last_ch_r <= sel_ch_s;
        psize     <= psize_max_s;
        ping_id   <= ping_id + 64'd1;
      end
      if (ping_ok_s) begin
        ping_time <= timer_r;
      end else if (ping_lost_s) begin
        plost_arr_r[cur_ch_r] <= plost_inc_s;
        ping_time     <= {LAT_W{1'b0}};
        pong_time     <= {LAT_W{1'b0}};
        status        <= 2'd1;
        done_ch       <= 4'(cur_ch_r);
        good_cnt      <= good_arr_r[cur_ch_r];
        ping_lost_cnt <= plost_inc_s;
        pong_lost_cnt <= polost_arr_r[cur_ch_r];
      end else if (pong_ok_s) begin
        good_arr_r[cur_ch_r] <= good_inc_s;
        pong_time     <= timer_r;
        status        <= 2'd0;
        done_ch       <= 4'(cur_ch_r);
        good_cnt      <= good_inc_s;
        ping_lost_cnt <= plost_arr_r[cur_ch_r];
        pong_lost_cnt <= polost_arr_r[cur_ch_r];
      end else if (pong_lost_s) begin
        polost_arr_r[cur_ch_r] <= polost_inc_s;
        ping_time     <= {LAT_W{1'b0}};
        pong_time     <= {LAT_W{1'b0}};
        status        <= 2'd2;
        done_ch       <= 4'(cur_ch_r);
        good_cnt      <= good_arr_r[cur_ch_r];
        ping_lost_cnt <= plost_arr_r[cur_ch_r];
        pong_lost_cnt <= polost_inc_s;
      end
    end
  end

endmodule

// File: doc/eth_measurer_multi_coord.md
ETH_MEASURER_MULTI_COORD -- requirements
Module: eth_measurer_multi_coord

Interface
REQ-001 Parameter NUM_CH, default 2, number of main/loop interface pairs measured in round-robin (1..16).
REQ-002 Parameter CNT_W, default 64, width of per-channel good/lost counters.
REQ-003 Parameter LAT_W, default 32, width of latency timer, timeout and delay.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  run ping-pong sequences while high.
REQ-007 ch_mask  in  NUM_CH  per-channel participation enable.
REQ-008 psize_req  in  16  requested padding bytes.
REQ-009 delay_time  in  LAT_W  idle cycles before each sequence.
REQ-010 timeout  in  LAT_W  max cycles to wait for ping or pong reception.
REQ-011 psize  out  16  padding latched for current sequence.
REQ-012 ping_id  out  64  identifier of current sequence.
REQ-013 main_tx_trigger / loop_tx_trigger  out  NUM_CH each  one-cycle TX start request per channel.
REQ-014 main_tx_begin / loop_tx_begin  in  NUM_CH each  one-cycle pulse, first byte accepted by TEMAC.
REQ-015 main_rx_valid / loop_rx_valid  in  NUM_CH each  one-cycle pulse, frame with identifier received.
REQ-016 main_rx_ping_id / loop_rx_ping_id  in  NUM_CH*64 each  packed received ids, channel c at bits [64c+63:64c].
REQ-017 done  out  1  one-cycle result strobe.
REQ-018 done_ch  out  4  channel of the result.
REQ-019 status  out  2  0 good, 1 ping lost, 2 pong lost.
REQ-020 ping_time / pong_time  out  LAT_W each  measured latencies.
REQ-021 good_cnt / ping_lost_cnt / pong_lost_cnt  out  CNT_W each  counters of done_ch, valid with done.

Function
REQ-022 FSM states IDLE, DELAY, PING_TX, PING_WAIT, PONG_TX, PONG_WAIT; transitions only as below.
REQ-023 IDLE: enable=1 and ch_mask!=0 -> DELAY with delay counter cleared.
REQ-024 DELAY: count cycles; when count==delay_time (delay_time=0: next cycle) select channel, latch psize, increment ping_id (wraps modulo 2^64), pulse main_tx_trigger[ch], -> PING_TX.
REQ-025 Channel select: next set ch_mask bit strictly after last served channel, wrapping; first sequence after reset starts search at channel 0; ch_mask==0 at selection -> IDLE, no trigger.
REQ-026 psize = max(psize_req, 38).
REQ-027 PING_TX: on main_tx_begin[ch] clear timer, -> PING_WAIT; begin pulses of other channels ignored.
REQ-028 PING_WAIT: timer +1 per cycle, saturating at 2^LAT_W-1; loop_rx_valid[ch] with loop_rx_ping_id[ch]==ping_id -> ping_time=timer, pulse loop_tx_trigger[ch], -> PONG_TX.
REQ-029 PING_WAIT timeout (timer==timeout, no match that cycle) -> ping_lost_cnt[ch]+1, done with status 1, ping_time=pong_time=0, -> DELAY.
REQ-030 Match and timeout in same cycle: match wins.
REQ-031 Mismatched id or other-channel rx pulse: ignored, timer continues.
REQ-032 PONG_TX / PONG_WAIT mirror REQ-027..030 with loop_tx_begin, main_rx_valid/main_rx_ping_id, pong_time, status 2, pong_lost_cnt.
REQ-033 Pong match -> good_cnt[ch]+1, done with status 0, both latencies, -> DELAY.
REQ-034 done asserted the cycle after the deciding event; counters presented are post-increment values; counters wrap modulo 2^CNT_W.
REQ-035 enable=0 in any state -> IDLE next cycle, no done, no counter change, triggers low.
REQ-036 ch_mask change mid-sequence does not abort the current channel.
REQ-037 TX states have no timeout; only enable=0 or rst exits them.

Reset
REQ-038 rst asserted -> immediately IDLE; all outputs 0, ping_id 0, psize 0, all counters 0, last-served channel = NUM_CH-1.
REQ-039 rst asserted mid-sequence discards the sequence; no done issued.

Verification
REQ-040 NUM_CH=2, mask=11, delay=3, timeout=100; begins after 2 cycles, ping match 10 cycles, pong match 12 -> done ch0 status 0 ping_time 10 pong_time 12 good 1; next sequence ch1 ping_id 2.
REQ-041 No loop rx after main begin, timeout=5 -> done status 1 at timer 5, ping_lost_cnt 1, good_cnt unchanged.
REQ-042 Wrong ping_id received then correct one -> only correct one ends PING_WAIT.
REQ-043 Match arrives on exact timeout cycle -> treated as good.
REQ-044 psize_req=20 -> psize 38; mask=10 -> only ch1 triggered, alternation absent.
REQ-045 enable or rst dropped in PONG_WAIT -> IDLE, no done, counters unchanged (rst: cleared).
